// File: rtl/rv_multicycle_datapath.sv
// Multi-cycle RV32I/RV64I-subset datapath and main-control FSM sharing one req/ready memory port.
// Latency 3-5 states per instruction plus memory wait cycles; illegal encodings or misaligned data park the core in a sticky TRAP.
module rv_multicycle_datapath #(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] program_counter,
  output logic            instr_retired,
  output logic            trap,
  output logic [2:0]      fsm_state
);

  localparam int         RIDX = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int         ALGN = (XLEN == 64) ? 3 : 2;
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_aluout;
  logic [XLEN-1:0] r_mdr;
  logic [XLEN-1:0] r_target;
  logic            r_trap;
  logic [XLEN-1:0] r_regs [NUM_REGS];

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;

  assign w_op  = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  logic w_is_add, w_is_sub, w_is_and, w_is_or, w_is_slt, w_is_r;
  logic w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_jal, w_legal;

  assign w_is_add  = (w_op == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
  assign w_is_sub  = (w_op == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0100000);
  assign w_is_slt  = (w_op == OP_R) && (w_f3 == 3'b010) && (w_f7 == 7'b0000000);
  assign w_is_or   = (w_op == OP_R) && (w_f3 == 3'b110) && (w_f7 == 7'b0000000);
  assign w_is_and  = (w_op == OP_R) && (w_f3 == 3'b111) && (w_f7 == 7'b0000000);
  assign w_is_r    = w_is_add | w_is_sub | w_is_slt | w_is_or | w_is_and;
  assign w_is_addi = (w_op == OP_IMM)    && (w_f3 == 3'b000);
  assign w_is_lw   = (w_op == OP_LOAD)   && (w_f3 == 3'b010);
  assign w_is_sw   = (w_op == OP_STORE)  && (w_f3 == 3'b010);
  assign w_is_beq  = (w_op == OP_BRANCH) && (w_f3 == 3'b000);
  assign w_is_jal  = (w_op == OP_JAL);
  assign w_legal   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_jal;

  // Only fields the format actually uses as register indices are range-checked;
  // in other formats those bits are immediate bits.
  logic w_use_rs1, w_use_rs2, w_use_rd, w_bad_reg, w_dec_trap;

  assign w_use_rs1  = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq;
  assign w_use_rs2  = w_is_r | w_is_sw | w_is_beq;
  assign w_use_rd   = w_is_r | w_is_addi | w_is_lw | w_is_jal;
  assign w_bad_reg  = (w_use_rs1 && ({1'b0, w_rs1} >= NREG)) ||
                      (w_use_rs2 && ({1'b0, w_rs2} >= NREG)) ||
                      (w_use_rd  && ({1'b0, w_rd}  >= NREG));
  assign w_dec_trap = !w_legal || w_bad_reg;

  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;

  assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_pc4, w_ea, w_alu;
  logic            w_misaligned;

  assign w_rs1_val    = r_regs[w_rs1[RIDX-1:0]];
  assign w_rs2_val    = r_regs[w_rs2[RIDX-1:0]];
  assign w_pc4        = r_pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign w_ea         = r_a + (w_is_sw ? w_imm_s : w_imm_i);
  assign w_misaligned = |w_ea[ALGN-1:0];

  always_comb begin
    w_alu = r_a + r_b;
    if (w_is_sub)       w_alu = r_a - r_b;
    else if (w_is_and)  w_alu = r_a & r_b;
    else if (w_is_or)   w_alu = r_a | r_b;
    else if (w_is_slt)  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
    else if (w_is_addi) w_alu = r_a + w_imm_i;
  end

  logic            w_retire, w_pc_we, w_rf_we;
  logic [XLEN-1:0] w_pc_nxt, w_rf_wdata;

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_nxt   = r_pc;
    w_rf_we    = 1'b0;
    w_rf_wdata = '0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_dec_trap ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_next = w_misaligned ? S_TRAP : S_MEM;
        end else if (w_is_beq) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_nxt = (r_a == r_b) ? r_target : w_pc4;
        end else if (w_is_jal) begin
          w_next     = S_FETCH;
          w_retire   = 1'b1;
          w_pc_we    = 1'b1;
          w_pc_nxt   = r_target;
          w_rf_we    = 1'b1;
          w_rf_wdata = w_pc4;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (w_is_sw) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
            w_pc_we  = 1'b1;
            w_pc_nxt = w_pc4;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_next     = S_FETCH;
        w_retire   = 1'b1;
        w_pc_we    = 1'b1;
        w_pc_nxt   = w_pc4;
        w_rf_we    = 1'b1;
        w_rf_wdata = w_is_lw ? r_mdr : r_aluout;
      end
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC[XLEN-1:0];
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_target <= '0;
      r_trap   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_trap <= 1'b1;
      if (r_state == S_FETCH && mem_ready) r_ir <= mem_rdata[31:0];
      if (r_state == S_DECODE) begin
        r_a      <= w_rs1_val;
        r_b      <= w_rs2_val;
        r_target <= r_pc + (w_is_jal ? w_imm_j : w_imm_b);
      end
      if (r_state == S_EXEC) r_aluout <= (w_is_lw || w_is_sw) ? w_ea : w_alu;
      if (r_state == S_MEM && mem_ready && w_is_lw) r_mdr <= mem_rdata;
      if (w_pc_we) r_pc <= w_pc_nxt;
      if (w_rf_we && (w_rd != 5'd0)) r_regs[w_rd[RIDX-1:0]] <= w_rf_wdata;
    end
  end

  // Fetch address drops PC[1:0] so a halfword-aligned branch target can never
  // present an unaligned address on the bus.
  assign mem_req         = !reset && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_we          = !reset && (r_state == S_MEM) && w_is_sw;
  assign mem_addr        = (r_state == S_MEM) ? r_aluout : {r_pc[XLEN-1:2], 2'b00};
  assign mem_wdata       = r_b;
  assign program_counter = r_pc;
  assign instr_retired   = w_retire && !reset;
  assign trap            = r_trap;
  assign fsm_state       = r_state;

endmodule

// File: tb/tb_rv_multicycle_datapath.sv
// Directed bench for rv_multicycle_datapath: small programs in a word memory with
// programmable ready delay, plus RV32E and 64-bit instances on fixed instruction ROMs.
module tb_rv_multicycle_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   wait_n = 0;

  // main instance: XLEN=32, NUM_REGS=32, RESET_PC=0
  logic        m_req, m_we, m_ready, retired, trap;
  logic [31:0] m_addr, m_wdata, m_rdata, pc;
  logic [2:0]  state;

  rv_multicycle_datapath #(.XLEN(32), .NUM_REGS(32), .RESET_PC(64'd0)) dut (
    .clock(clk), .reset(rst),
    .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata), .mem_ready(m_ready),
    .program_counter(pc), .instr_retired(retired), .trap(trap), .fsm_state(state)
  );

  logic [31:0] mem  [256];
  logic [31:0] prog [256];
  int          wcnt;

  assign m_rdata = mem[m_addr[9:2]];
  assign m_ready = m_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wcnt <= 0;
    end else begin
      if (m_req && m_we && m_ready) mem[m_addr[9:2]] <= m_wdata;
      if (!m_req || m_ready) wcnt <= 0;
      else                   wcnt <= wcnt + 1;
    end
  end

  // RV32E instance: add x17,x1,x2 at address 0
  logic        e_req, e_we, e_ret, e_trap;
  logic [31:0] e_addr, e_wdata, e_rdata, e_pc;
  logic [2:0]  e_state;

  assign e_rdata = (e_addr == 32'd0) ? {7'd0, 5'd2, 5'd1, 3'b000, 5'd17, 7'b0110011} : 32'h0000006F;

  rv_multicycle_datapath #(.XLEN(32), .NUM_REGS(16), .RESET_PC(64'd0)) dut_e (
    .clock(clk), .reset(rst),
    .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr), .mem_wdata(e_wdata),
    .mem_rdata(e_rdata), .mem_ready(1'b1),
    .program_counter(e_pc), .instr_retired(e_ret), .trap(e_trap), .fsm_state(e_state)
  );

  // 64-bit instance: addi x1,x0,-1 ; sw x1,0x10(x0) ; then jal x0,0 forever
  logic        d_req, d_we, d_ret, d_trap;
  logic [63:0] d_addr, d_wdata, d_rdata, d_pc;
  logic [2:0]  d_state;
  logic [63:0] d_wr_addr = '0, d_wr_data = '0;

  assign d_rdata = (d_addr == 64'd0) ? 64'h00000000_FFF00093 :
                   (d_addr == 64'd4) ? {32'd0, 7'd0, 5'd1, 5'd0, 3'b010, 5'b10000, 7'b0100011} :
                                       64'h00000000_0000006F;

  rv_multicycle_datapath #(.XLEN(64), .NUM_REGS(32), .RESET_PC(64'd0)) dut_d (
    .clock(clk), .reset(rst),
    .mem_req(d_req), .mem_we(d_we), .mem_addr(d_addr), .mem_wdata(d_wdata),
    .mem_rdata(d_rdata), .mem_ready(1'b1),
    .program_counter(d_pc), .instr_retired(d_ret), .trap(d_trap), .fsm_state(d_state)
  );

  always @(negedge clk) begin
    if (!rst && d_req && d_we) begin
      d_wr_addr = d_addr;
      d_wr_data = d_wdata;
    end
  end

  // cycle 1 = first cycle after reset release
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= rst ? 1 : cyc_cnt + 1;

  int          nret = 0, nwr = 0, stab_err = 0;
  int          ret_cyc  [16];
  logic [31:0] pc_after [16];
  logic [31:0] wr_addr  [8];
  logic [31:0] wr_data  [8];
  logic        rec_pc = 1'b0, waiting = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      nret = 0; nwr = 0; stab_err = 0; rec_pc = 1'b0; waiting = 1'b0;
    end else begin
      if (rec_pc) begin
        pc_after[nret-1] = pc;
        rec_pc = 1'b0;
      end
      if (retired && nret < 16) begin
        ret_cyc[nret] = cyc_cnt;
        nret++;
        rec_pc = 1'b1;
      end
      if (m_req && m_we && m_ready && nwr < 8) begin
        wr_addr[nwr] = m_addr;
        wr_data[nwr] = m_wdata;
        nwr++;
      end
      if (!m_req) begin
        waiting = 1'b0;
      end else begin
        if (waiting && (m_addr != h_addr || m_we != h_we || (m_we && m_wdata != h_wdata))) stab_err++;
        if (!waiting) begin
          h_addr = m_addr; h_we = m_we; h_wdata = m_wdata; waiting = 1'b1;
        end
        if (m_ready) waiting = 1'b0;
      end
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000006F;
  endtask

  task automatic do_reset(input int w);
    @(posedge clk); #2;
    rst = 1'b1;
    wait_n = w;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (nret < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, nret, n);
    @(negedge clk); #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  initial begin
    clear_prog();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req",    m_req,   0);
    check("rst_state",  state,   0);
    check("rst_pc",     pc,      0);
    check("rst_trap",   trap,    0);
    check("rst_retire", retired, 0);

    // arithmetic sequence, zero-wait memory
    clear_prog();
    prog[0] = i_type(12'd5,   5'd0, 3'b000, 5'd1, OPI);
    prog[1] = i_type(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
    prog[2] = r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
    prog[3] = r_type(7'd0, 5'd1, 5'd2, 3'b010, 5'd4);
    prog[4] = s_type(12'h080, 5'd3, 5'd0);
    prog[5] = s_type(12'h084, 5'd4, 5'd0);
    do_reset(0);
    run_until(6, 60, "a_timeout");
    check("a_ret0", ret_cyc[0], 4);
    check("a_ret1", ret_cyc[1], 8);
    check("a_ret2", ret_cyc[2], 12);
    check("a_ret3", ret_cyc[3], 16);
    check("a_pc",   pc_after[3], 32'h10);
    check("a_x3",   mem[32], 32'd2);
    check("a_x4",   mem[33], 32'd1);
    check("e_trap",  e_trap,  1);
    check("e_state", e_state, 5);
    check("e_pc",    e_pc,    0);
    check("d_waddr", d_wr_addr, 64'h10);
    check("d_wdata", d_wr_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // store then load with three wait cycles per request
    clear_prog();
    prog[0]  = i_type(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    prog[1]  = j_type(21'h3C, 5'd0);
    prog[16] = s_type(12'h008, 5'd1, 5'd0);
    prog[17] = i_type(12'h008, 5'd0, 3'b010, 5'd5, OPL);
    prog[18] = s_type(12'h088, 5'd5, 5'd0);
    do_reset(3);
    run_until(5, 200, "b_timeout");
    check("b_nwr",   nwr, 2);
    check("b_waddr", wr_addr[0], 32'h8);
    check("b_wdata", wr_data[0], 32'h5);
    check("b_lw_cycles", ret_cyc[3] - ret_cyc[2], 11);
    check("b_x5",    mem[34], 32'd5);
    check("b_stable", stab_err, 0);

    // beq taken at 0x20
    clear_prog();
    prog[0] = i_type(12'd5,   5'd0, 3'b000, 5'd1, OPI);
    prog[1] = i_type(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
    prog[2] = j_type(21'h18, 5'd0);
    prog[8] = b_type(13'h1FF8, 5'd1, 5'd1);
    do_reset(0);
    run_until(4, 60, "c1_timeout");
    check("c1_jal_pc",  pc_after[2], 32'h20);
    check("c1_pc",      pc_after[3], 32'h18);
    check("c1_cycles",  ret_cyc[3] - ret_cyc[2], 3);

    // beq not taken at 0x20
    prog[8] = b_type(13'd8, 5'd2, 5'd1);
    do_reset(0);
    run_until(4, 60, "c2_timeout");
    check("c2_pc",      pc_after[3], 32'h24);
    check("c2_cycles",  ret_cyc[3] - ret_cyc[2], 3);

    // jal link and x0 hardwiring
    clear_prog();
    prog[0]  = j_type(21'h40, 5'd0);
    prog[16] = j_type(21'h100, 5'd1);
    prog[80] = i_type(12'd7, 5'd0, 3'b000, 5'd0, OPI);
    prog[81] = s_type(12'h090, 5'd1, 5'd0);
    prog[82] = s_type(12'h094, 5'd0, 5'd0);
    prog[37] = 32'hDEADBEEF;
    do_reset(0);
    run_until(5, 80, "d_timeout");
    check("d_pc",  pc_after[1], 32'h140);
    check("d_x1",  mem[36], 32'h44);
    check("d_x0",  mem[37], 32'h0);

    // illegal opcode at 0x4
    clear_prog();
    prog[0] = i_type(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    prog[1] = 32'h0000007F;
    do_reset(0);
    run_cycles(12);
    check("ill_trap",  trap,  1);
    check("ill_state", state, 5);
    check("ill_req",   m_req, 0);
    check("ill_pc",    pc,    32'h4);
    check("ill_nret",  nret,  1);
    do_reset(0);
    @(negedge clk); #1;
    check("ill_rst_state", state, 0);
    check("ill_rst_pc",    pc,    0);
    check("ill_rst_trap",  trap,  0);

    // misaligned load address 0x6
    clear_prog();
    prog[0] = i_type(12'd6, 5'd0, 3'b000, 5'd1, OPI);
    prog[1] = i_type(12'd0, 5'd1, 3'b010, 5'd5, OPL);
    do_reset(0);
    run_cycles(12);
    check("mis_trap",  trap,  1);
    check("mis_state", state, 5);
    check("mis_req",   m_req, 0);
    check("mis_pc",    pc,    32'h4);

    // reset during a pending fetch
    clear_prog();
    prog[0] = i_type(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    do_reset(20);
    @(negedge clk); #1;
    check("g_pending_req", m_req, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #1;
    check("g_rst_req",   m_req, 0);
    check("g_rst_state", state, 0);
    do_reset(0);
    run_until(1, 20, "g_timeout");
    check("g_ret0", ret_cyc[0], 4);
    check("g_pc",   pc_after[0], 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/rv_multicycle_datapath.md
Name: rv_multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I datapath. Datapath and main-control FSM live in one block.
- Executes one instruction over 3-5 states through a single unified memory port with a req/ready handshake, so instruction and data memories are no longer separate.
- Register file depth and data width are generalised. Adds illegal-instruction/misalignment trap and a retire pulse for the core wrapper and perf counters.

Parameters:
- XLEN, 32, datapath/register width (32 or 64); instructions always 32 bits, taken from mem_rdata[31:0].
- NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E); x0 hardwired to 0.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  XLEN  byte address; bits [1:0] always 0 when mem_req=1
- mem_wdata  out  XLEN  store data (rs2)
- mem_rdata  in  XLEN  read data; valid when mem_ready=1
- mem_ready  in  1  completes the current request this cycle
- program_counter  out  XLEN  architectural PC of the instruction in flight
- instr_retired  out  1  one-cycle pulse in the final state of each instruction
- trap  out  1  sticky; set on illegal opcode, register index >= NUM_REGS, or misaligned data address
- fsm_state  out  3  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (sync): state=FETCH; PC=RESET_PC; IR, A, B, ALUOut, MDR and all registers cleared; trap=0; instr_retired=0. mem_req is gated to 0 in every cycle reset is high. A reset asserted mid-request abandons the transaction; mem_ready that cycle is ignored.
- Supported: add, sub, and, or, slt (R); addi (I); lw, sw, beq, jal. slt is a signed XLEN compare. All immediates sign-extend to XLEN. lw/sw transfer a full XLEN word.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stays in FETCH while mem_ready=0; address is held stable. On mem_ready: IR<=mem_rdata[31:0], go to DECODE.
- DECODE:
  - Read rs1/rs2 into A/B; Target<=PC+imm (B- or J-type).
  - Unknown opcode/funct, or any rs1/rs2/rd >= NUM_REGS: go to TRAP.
- EXEC:
  - R/addi: ALUOut<=result, go to WB.
  - lw/sw: ALUOut<=A+imm. If ALUOut[1:0]!=0 (XLEN=64: [2:0]), go to TRAP; otherwise go to MEM.
  - beq: PC<=(A==B)?Target:PC+4; pulse retire; go to FETCH.
  - jal: rd<=PC+4 (unless rd=0); PC<=Target; pulse retire; go to FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B; hold until mem_ready.
  - lw: MDR<=mem_rdata, go to WB.
  - sw: PC<=PC+4, pulse retire, go to FETCH.
- WB: rd<=ALUOut or MDR (suppressed if rd=0); PC<=PC+4; pulse retire; go to FETCH.
- TRAP: trap=1, mem_req=0, PC frozen at the faulting instruction. Only reset exits TRAP.
- Latency with zero-wait memory (mem_ready tied high): beq/jal 3 cycles; R/addi/sw 4; lw 5. Each wait cycle adds one.
- PC arithmetic wraps modulo 2^XLEN. A register write and a read of the same register cannot coincide, because reads occur only in DECODE.
- mem_req never asserts outside FETCH/MEM. Handshake: mem_addr, mem_we and mem_wdata are stable from mem_req rise until the mem_ready cycle.

Test Plan:
- Reset, then run "addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1" from RESET_PC=0, ready tied 1 -> x3=2, x4=1; retire pulses at cycles 4, 8, 12, 16; PC=16.
- sw x1,8(x0) then lw x5,8(x0), with mem_ready delayed 3 cycles on every request -> write addr 8 data 5; x5=5; lw takes 5+6 cycles; addr/we/wdata constant while waiting.
- beq x1,x1,-8 taken vs beq x1,x2,+8 not taken at PC=0x20 -> PC 0x18 vs 0x24; 3 cycles each.
- jal x1,+0x100 at PC=0x40 -> x1=0x44, PC=0x140; addi x0,x0,7 leaves x0=0.
- Illegal opcode 0x0000007F, and lw at address 0x6 -> trap=1, fsm_state=5, mem_req=0, PC holds the faulting address; reset returns to FETCH with PC=RESET_PC.
- NUM_REGS=16, add x17,x1,x2 -> trap; XLEN=64, addi x1,x0,-1 -> x1=0xFFFF_FFFF_FFFF_FFFF; reset asserted during a pending FETCH -> mem_req=0 next cycle, clean restart.
